// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned nbeats(input int unsigned width, input int unsigned bpc);
    return (bpc == 0) ? 1 : width / bpc;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// 1-bit full-adder cell; one slice of the serial adder's per-beat ripple chain.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds BITS_PER_CYCLE bits per beat with a registered carry.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBeats = nbeats(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CntW   = cnt_width(NBeats);
  localparam logic [CntW-1:0] LastBeat = CntW'(NBeats - 1);

  if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || (BITS_PER_CYCLE > WIDTH) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_err
    $error("serial_adder: BITS_PER_CYCLE must be >= 1 and divide WIDTH exactly");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [WIDTH-1:0] acc_shift;
  logic            carry_q, carry_d, cout_q, cout_d;

  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic [BITS_PER_CYCLE:0]   chain;

`ifdef SERIAL_ADDER_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  assign chain[0] = carry_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
    fulladder u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (chain[i]),
      .s    (slice_s[i]),
      .cout (chain[i+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    // Result bits enter at the MSB end so the last beat leaves them aligned.
    acc_shift = acc_q >> BITS_PER_CYCLE;
    acc_shift[WIDTH-1 -: BITS_PER_CYCLE] = slice_s;
`ifdef SERIAL_ADDER_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SERIAL_ADDER_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      StRun: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        acc_d   = acc_shift;
        carry_d = chain[BITS_PER_CYCLE];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBeat) begin
          sum_d   = acc_shift;
          cout_d  = chain[BITS_PER_CYCLE];
          state_d = StDone;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d = (a_msb_q == b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
`endif
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit/1-bit-per-beat and 8-bit/4-bit-per-beat instances.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [7:0] a, b, sum;
  logic       q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_cin, q_cout, q_ovf;
  logic [7:0] q_a, q_b, q_sum;

  exp_t sb[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (q_in_valid),
    .in_ready  (q_in_ready),
    .a         (q_a),
    .b         (q_b),
    .cin       (q_cin),
    .out_valid (q_out_valid),
    .out_ready (q_out_ready),
    .sum       (q_sum),
    .cout      (q_cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (q_ovf)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf   = 1'b0;
  assign q_ovf = 1'b0;
`endif

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    exp_t e;
    t      = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (x[7] == y[7]) && (t[7] != x[7]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge with the DUT idle; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    sb.push_back(model(x, y, c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    if (sb.size() > 0) begin
      last_e = sb.pop_front();
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, last_e.sum});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, last_e.cout});
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, last_e.ovf});
`endif
    end
  endtask

  // Output handshake with out_ready high; result must persist afterwards.
  task automatic release_out(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_rel_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rel_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_rel_sum_held"}, {24'd0, sum}, {24'd0, last_e.sum});
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    q_in_valid  = 1'b0;
    q_out_ready = 1'b1;
    q_a         = '0;
    q_b         = '0;
    q_cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst4_in_ready", {31'd0, q_in_ready}, 32'd1);
    check("rst4_out_valid", {31'd0, q_out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'h5A, 8'h33, 1'b0);
    wait_out("t5a33", 8);
    check("t5a33_const_sum", {24'd0, sum}, 32'h8D);
    release_out("t5a33");

    send(8'hFF, 8'h01, 1'b0);
    wait_out("tff01", 8);
    check("tff01_const_cout", {31'd0, cout}, 32'd1);
    release_out("tff01");

    send(8'hFF, 8'hFF, 1'b1);
    wait_out("tffff", 8);
    check("tffff_const_sum", {24'd0, sum}, 32'hFF);
    release_out("tffff");

    send(8'h7F, 8'h01, 1'b0);
    wait_out("t7f01", 8);
    release_out("t7f01");

    send(8'h80, 8'hFF, 1'b0);
    wait_out("t80ff", 8);
    release_out("t80ff");

    // Backpressure: result held and a stray in_valid is ignored.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1);
    wait_out("bp", 8);
    for (int i = 0; i < 5; i++) begin
      a        = 8'hAA;
      b        = 8'h55;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_sum", {24'd0, sum}, {24'd0, last_e.sum});
      check("bp_cout", {31'd0, cout}, {31'd0, last_e.cout});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    release_out("bp");
    @(posedge clk);
    #1;
    check("bp_still_idle", {31'd0, in_ready}, 32'd1);

    // Reset during RUN aborts the operation.
    send(8'h44, 8'h55, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {24'd0, sum}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    send(8'h10, 8'h20, 1'b0);
    wait_out("t1020", 8);
    check("t1020_const_sum", {24'd0, sum}, 32'h30);
    release_out("t1020");

    // Four bits per beat: two beats.
    begin
      int n = 0;
      check("q_in_ready", {31'd0, q_in_ready}, 32'd1);
      q_a        = 8'h9C;
      q_b        = 8'h67;
      q_cin      = 1'b1;
      q_in_valid = 1'b1;
      @(posedge clk);
      #1;
      q_in_valid = 1'b0;
      while (q_out_valid !== 1'b1 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("q_lat", n, 2);
      check("q_sum", {24'd0, q_sum}, 32'h04);
      check("q_cout", {31'd0, q_cout}, 32'd1);
      @(posedge clk);
      #1;
      check("q_rel_out_valid", {31'd0, q_out_valid}, 32'd0);
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder: sums two WIDTH-bit operands plus carry-in over WIDTH/BITS_PER_CYCLE clock cycles.
- Processes BITS_PER_CYCLE bits per beat through a chain of 1-bit full-adder slices.
- Carry is held in a register between beats.
- Valid/ready handshake on both input and output. Datapath building block for the upcoming ALU/accumulator labs; replaces the purely combinational 1-bit cell at system level.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits added per beat; must divide WIDTH exactly. Violation -> elaboration-time $error.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

Behaviour:
- Reset: rst_n sampled low at a rising clk edge -> state IDLE, beat counter 0, carry register 0, operand shift registers 0.
  - Output values during/after reset: sum=0, cout=0, out_valid=0, in_ready=1, ovf=0.
  - Reset overrides all other inputs.
- FSM states: IDLE, RUN, DONE. NBEATS = WIDTH/BITS_PER_CYCLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture a, b into shift registers and cin into the carry register; beat counter cleared -> RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: add the low BITS_PER_CYCLE bits of each shift register plus the carry register.
  - Shift both operand registers right by BITS_PER_CYCLE.
  - Shift the slice sums into the result register from the MSB end.
  - Update the carry register with the chain's carry-out; counter++.
  - After beat NBEATS-1 -> DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum/cout held stable while out_ready=0.
  - On out_ready=1 -> IDLE.
- Latency: in handshake at edge T -> out_valid high after edge T+NBEATS. Minimum accept-to-accept interval is NBEATS+2 cycles.
- in_ready is high only in IDLE. in_valid in RUN/DONE is ignored and not stored.
- sum/cout keep their last value after the output handshake; they are not cleared until the next result or reset.
- Width/arithmetic rules:
  - Sum wraps modulo 2^WIDTH. cout = bit WIDTH of a+b+cin.
  - Example: all-ones + all-ones + 1 -> sum all-ones, cout=1.
- WIDTH=1, BITS_PER_CYCLE=1: NBEATS=1, behaves as a registered full adder with handshake.
- Reset mid-RUN or in DONE: the operation is aborted and the result is lost; the FSM returns to IDLE next cycle.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Port ovf exists, updated with sum.
  - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the MSB values captured at input handshake.
  - Held in DONE; reset value 0.
- Undefined: port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE) as a 2-bit typedef.
  - function nbeats(WIDTH, BITS_PER_CYCLE).
  - function clog2-based counter width.
- Sub-module: instantiate the team's existing 1-bit fulladder cell (ports a, b, cin, s, cout) BITS_PER_CYCLE times in a generate loop as the per-beat ripple slice. No other sub-modules.

Test Plan:
- WIDTH=8, BPC=1: a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid 8 cycles after accept; sum=0x8D, cout=0.
- WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable; in_ready=0; an extra in_valid pulse is not accepted.
- Reset mid-RUN: drop rst_n at beat 3 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0. New transaction 0x10+0x20 -> sum=0x30.
- WIDTH=8, BPC=4: a=0x9C, b=0x67, cin=1 -> out_valid 2 cycles after accept; sum=0x04, cout=1.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, ovf=1; 0x80+0xFF -> sum=0x7F, cout=1, ovf=1; 0x10+0x20 -> ovf=0.
